// File: rtl/uart_alu_intf.sv
// uart_alu_intf: collects A, B and opcode bytes from uart_rx, latches the ALU result and hands it to uart_tx.
module uart_alu_intf #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b,
  output logic [OP_WIDTH-1:0]   o_op,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_overrun
);
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, RESULT, SEND, WAIT_TX} state_t;
  state_t state, state_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= GET_A;
      o_data_a  <= '0;
      o_data_b  <= '0;
      o_op      <= '0;
      o_tx_data <= '0;
      o_overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (i_rx_done && state == GET_A) o_data_a <= i_rx_data;
      if (i_rx_done && state == GET_B) o_data_b <= i_rx_data;
      if (i_rx_done && state == GET_OP) o_op <= i_rx_data[OP_WIDTH-1:0];
      if (state == RESULT) o_tx_data <= i_alu_result;
      if (i_rx_done && o_busy) o_overrun <= 1'b1;
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      GET_A:   state_next = i_rx_done ? GET_B : GET_A;
      GET_B:   state_next = i_rx_done ? GET_OP : GET_B;
      GET_OP:  state_next = i_rx_done ? RESULT : GET_OP;
      RESULT:  state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: state_next = i_tx_done ? GET_A : WAIT_TX;
      default: state_next = GET_A;
    endcase
  end
  assign o_tx_start = state == SEND;
  assign o_busy     = state == RESULT || state == SEND || state == WAIT_TX;
endmodule

// File: tb/tb_uart_alu_intf.sv
// tb_uart_alu_intf: table-driven commands with a scoreboard of expected result bytes plus hand-written handshake/reset sequences.
module tb_uart_alu_intf;
  logic       clk = 0, reset = 1, rx_done = 0, tx_done = 0;
  logic [7:0] rx_data = 0, alu_result, data_a, data_b, tx_data;
  logic [5:0] op;
  logic       tx_start, busy, overrun, prev_start = 0;
  int         checks = 0, failures = 0;
  logic [7:0] sb[$];
  typedef struct {
    logic [7:0] a, b, opb;
    logic [5:0] op;
    logic [7:0] res;
  } vec_t;
  vec_t vec[3];

  uart_alu_intf dut (
    .clk(clk), .reset(reset), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_alu_result(alu_result), .i_tx_done(tx_done), .o_data_a(data_a),
    .o_data_b(data_b), .o_op(op), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  assign alu_result = op == 6'h20 ? data_a + data_b : op == 6'h22 ? data_a - data_b : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && tx_start) begin
      chk("start_single", {31'b0, prev_start}, 0);
      if (sb.size() == 0) chk("sb_unexpected_start", 1, 0);
      else chk("tx_data", {24'b0, tx_data}, {24'b0, sb.pop_front()});
    end
    prev_start <= tx_start;
  end

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge clk) #1;
    rx_done = 1;
    rx_data = b;
    @(posedge clk) #1;
    rx_done = 0;
  endtask

  // Called right after the opcode pulse has been sampled: t+1 is RESULT, t+2 SEND, t+3 WAIT_TX.
  task automatic post_checks(input logic [7:0] ea, input logic [7:0] eb, input logic [5:0] eop);
    @(negedge clk);
    chk("data_a", {24'b0, data_a}, {24'b0, ea});
    chk("data_b", {24'b0, data_b}, {24'b0, eb});
    chk("op", {26'b0, op}, {26'b0, eop});
    chk("start_t1", {31'b0, tx_start}, 0);
    chk("busy_t1", {31'b0, busy}, 1);
    @(negedge clk);
    chk("start_t2", {31'b0, tx_start}, 1);
    repeat (3) @(negedge clk);
    chk("start_wait", {31'b0, tx_start}, 0);
    chk("busy_wait", {31'b0, busy}, 1);
  endtask

  task automatic run_tail(input logic [7:0] ea, input logic [7:0] b, input logic [7:0] opb,
                          input logic [5:0] eop, input logic [7:0] res);
    sb.push_back(res);
    pulse_rx(b);
    pulse_rx(opb);
    post_checks(ea, b, eop);
  endtask

  // Optionally drives an rx pulse in the cycle right after the accepting tx_done.
  task automatic do_tx_done(input logic nv, input logic [7:0] nb);
    @(posedge clk) #1;
    tx_done = 1;
    @(posedge clk) #1;
    tx_done = 0;
    rx_done = nv;
    rx_data = nb;
    if (nv) begin
      @(posedge clk) #1;
      rx_done = 0;
    end
    @(negedge clk);
    chk("busy_after_tx", {31'b0, busy}, 0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {busy, tx_start, overrun, op, tx_data, data_b, data_a}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vec[1] = '{8'hFF, 8'h02, 8'h20, 6'h20, 8'h01};
    vec[2] = '{8'h03, 8'h05, 8'hE2, 6'h22, 8'hFE};
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    @(posedge clk) #1;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_rx(vec[i].a);
      run_tail(vec[i].a, vec[i].b, vec[i].opb, vec[i].op, vec[i].res);
      do_tx_done(0, 0);
    end
    chk("overrun_clean", {31'b0, overrun}, 0);
    // overrun while waiting for the transmitter, then an operand A right after tx_done
    pulse_rx(8'h07);
    run_tail(8'h07, 8'h01, 8'h20, 6'h20, 8'h08);
    pulse_rx(8'h11);
    @(negedge clk);
    chk("overrun_set", {31'b0, overrun}, 1);
    chk("a_kept", {24'b0, data_a}, 8'h07);
    do_tx_done(1, 8'h01);
    run_tail(8'h01, 8'h01, 8'h20, 6'h20, 8'h02);
    chk("overrun_sticky", {31'b0, overrun}, 1);
    do_tx_done(0, 0);
    // reset mid-command
    pulse_rx(8'h05);
    pulse_rx(8'h03);
    @(posedge clk) #1;
    reset = 1;
    @(negedge clk);
    chk_zero("reset_mid");
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 0;
    pulse_rx(8'h0A);
    run_tail(8'h0A, 8'h0B, 8'h20, 6'h20, 8'h15);
    do_tx_done(0, 0);
    // tx_done while in GET_B is ignored
    pulse_rx(8'h09);
    @(posedge clk) #1;
    tx_done = 1;
    @(posedge clk) #1;
    tx_done = 0;
    run_tail(8'h09, 8'h04, 8'h22, 6'h22, 8'h05);
    // rx_done coincident with the accepting tx_done is dropped
    chk("overrun_pre", {31'b0, overrun}, 0);
    @(posedge clk) #1;
    tx_done = 1;
    rx_done = 1;
    rx_data = 8'h77;
    @(posedge clk) #1;
    tx_done = 0;
    rx_done = 0;
    @(negedge clk);
    chk("coinc_overrun", {31'b0, overrun}, 1);
    chk("coinc_busy", {31'b0, busy}, 0);
    chk("coinc_a_kept", {24'b0, data_a}, 8'h09);
    // back-to-back bytes on consecutive cycles
    sb.push_back(8'h0A);
    @(posedge clk) #1;
    rx_done = 1;
    rx_data = 8'h04;
    @(posedge clk) #1;
    rx_data = 8'h06;
    @(posedge clk) #1;
    rx_data = 8'h20;
    @(posedge clk) #1;
    rx_done = 0;
    post_checks(8'h04, 8'h06, 6'h20);
    do_tx_done(0, 0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
